// File: rtl/mac_feeder_pkg.sv
// Shared definitions for the MAC array feeder and the array it drives:
// array geometry, FSM state encodings and lane slicing helpers.
package mac_feeder_pkg;

    localparam int MF_LANES = 5;
    localparam int MF_DW    = 8;
    localparam int MF_BUS_W = MF_LANES * MF_DW;

    // Feeder FSM state encodings
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LOAD_W = 3'd1;
    localparam state_t S_STREAM = 3'd2;
    localparam state_t S_DRAIN  = 3'd3;
    localparam state_t S_DONE   = 3'd4;

    // Lane 0 lives in the most significant byte of a row bus.
    function automatic int lane_lo(input int lane, input int lanes, input int dw);
        return (lanes - 1 - lane) * dw;
    endfunction

    function automatic int lane_hi(input int lane, input int lanes, input int dw);
        return (lanes - lane) * dw - 1;
    endfunction

endpackage

// File: rtl/mac_feeder_skew_lane.sv
// One lane of the diagonal skew: a DEPTH-stage shift register carrying a
// byte plus a valid bit. Invalid slots carry zero data so the array sees
// 0x00 on bubbles without any output masking.
module mac_skew_lane #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          vld_i,
    input  logic [DW-1:0] data_i,
    output logic          vld_o,
    output logic [DW-1:0] data_o,
    output logic          pend_o
);

    logic [DEPTH-1:0]         vld_q;
    logic [DEPTH-1:0][DW-1:0] data_q;

    // Shift every cycle; the array applies no back-pressure.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0]  <= vld_i;
            data_q[0] <= vld_i ? data_i : '0;
            for (int j = 1; j < DEPTH; j++) begin
                vld_q[j]  <= vld_q[j-1];
                data_q[j] <= data_q[j-1];
            end
        end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign data_o = data_q[DEPTH-1];

    // Valid data that will still be in the lane after the next shift.
    generate
        if (DEPTH > 1) begin : g_pend
            assign pend_o = |vld_q[DEPTH-2:0];
        end else begin : g_nopend
            assign pend_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mac_feeder.sv
// Feeds a LANES x LANES MAC array: loads LANES weight rows, then streams
// activation rows with a per-lane diagonal skew (lane i delayed 1+i cycles),
// drains the skew pipeline and pulses done_o once per tile.
module mac_feeder
    import mac_feeder_pkg::*;
#(
    parameter int LANES = MF_LANES,
    parameter int DW    = MF_DW
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                w_valid_i,
    input  logic [LANES*DW-1:0] w_data_i,
    output logic                w_ready_o,
    input  logic                x_valid_i,
    input  logic [LANES*DW-1:0] x_data_i,
    input  logic                x_last_i,
    output logic                x_ready_o,
    output logic [LANES*DW-1:0] Weight_o,
    output logic                enW_o,
    output logic [LANES*DW-1:0] In_o,
    output logic                enI_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [2:0] CNT_LAST = 3'(LANES - 1);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [LANES*DW-1:0] weight_q;
    logic                enw_q;
    logic                w_acc, x_acc;
    logic [LANES-1:0]    lane_vld, lane_pend;

    assign w_ready_o = (state_q == S_IDLE) || (state_q == S_LOAD_W);
    assign x_ready_o = (state_q == S_STREAM);
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign w_acc     = w_valid_i & w_ready_o;
    assign x_acc     = x_valid_i & x_ready_o;

    // Next-state and weight-row counter; the IDLE acceptance is row 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_acc) begin
                    cnt_d   = 3'd1;
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                if (w_acc) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = 3'd0;
                        state_d = S_STREAM;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_STREAM: begin
                if (x_acc && x_last_i) state_d = S_DRAIN;
            end
            // Leave as soon as nothing valid survives the next shift, so the
            // done pulse directly follows the last skewed byte.
            S_DRAIN: begin
                if (lane_pend == '0) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and weight output registers.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            weight_q <= '0;
            enw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            enw_q   <= w_acc;
            if (w_acc) weight_q <= w_data_i;
        end
    end

    assign Weight_o = weight_q;
    assign enW_o    = enw_q;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            mac_skew_lane #(
                .DEPTH (1 + gi),
                .DW    (DW)
            ) u_lane (
                .CLK    (CLK),
                .RSTN   (RSTN),
                .vld_i  (x_acc),
                .data_i (x_data_i[lane_hi(gi, LANES, DW):lane_lo(gi, LANES, DW)]),
                .vld_o  (lane_vld[gi]),
                .data_o (In_o[lane_hi(gi, LANES, DW):lane_lo(gi, LANES, DW)]),
                .pend_o (lane_pend[gi])
            );
        end
    endgenerate

    assign enI_o = |lane_vld;

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder: weight load, skewed streaming with bubbles,
// ignored weight offers and x_last, and reset in the middle of DRAIN.
module tb_mac_feeder;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        w_valid_i = 1'b0;
    logic [39:0] w_data_i = '0;
    logic        w_ready_o;
    logic        x_valid_i = 1'b0;
    logic [39:0] x_data_i = '0;
    logic        x_last_i = 1'b0;
    logic        x_ready_o;
    logic [39:0] Weight_o;
    logic        enW_o;
    logic [39:0] In_o;
    logic        enI_o;
    logic        busy_o;
    logic        done_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [39:0] rows [0:3];
    logic        rv   [0:3];

    always #5 CLK = ~CLK;

    mac_feeder dut (
        .CLK(CLK), .RSTN(RSTN),
        .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
        .x_valid_i(x_valid_i), .x_data_i(x_data_i), .x_last_i(x_last_i),
        .x_ready_o(x_ready_o), .Weight_o(Weight_o), .enW_o(enW_o),
        .In_o(In_o), .enI_o(enI_o), .busy_o(busy_o), .done_o(done_o)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Five weight rows 0x0101010101..0x0505050505 on consecutive cycles.
    task automatic load_weights;
        for (int r = 1; r <= 5; r++) begin
            logic [7:0] b;
            b = 8'(r);
            chk("w_ready_load", 64'(w_ready_o), 64'd1);
            w_valid_i = 1'b1;
            w_data_i  = {5{b}};
            tick;
            chk("Weight_o", 64'(Weight_o), 64'({5{b}}));
            chk("enW_o", 64'(enW_o), 64'd1);
            chk("busy_load", 64'(busy_o), 64'd1);
        end
        w_valid_i = 1'b0;
        w_data_i  = '0;
        chk("x_ready_stream", 64'(x_ready_o), 64'd1);
        chk("w_ready_stream", 64'(w_ready_o), 64'd0);
    endtask

    // Offer rows[0..n-1] (rv gates x_valid_i), last on row n-1, then check
    // the skewed output until the FSM is back in IDLE.
    task automatic stream_tile(input int n);
        logic [39:0] exp_in;
        logic        exp_en;
        for (int t = 0; t < n + 6; t++) begin
            if (t < n) begin
                chk("x_ready_tile", 64'(x_ready_o), 64'd1);
                x_valid_i = rv[t];
                x_data_i  = rows[t];
                x_last_i  = (t == n - 1);
            end
            tick;
            x_valid_i = 1'b0;
            x_data_i  = '0;
            x_last_i  = 1'b0;
            exp_in = '0;
            exp_en = 1'b0;
            for (int i = 0; i < 5; i++) begin
                int k;
                k = t - i;
                if (k >= 0 && k < n && rv[k]) begin
                    exp_in[(4-i)*8 +: 8] = rows[k][(4-i)*8 +: 8];
                    exp_en = 1'b1;
                end
            end
            chk("In_o", 64'(In_o), 64'(exp_in));
            chk("enI_o", 64'(enI_o), 64'(exp_en));
            chk("done_o", 64'(done_o), 64'(t == n + 4));
            chk("busy_tile", 64'(busy_o), 64'(t <= n + 4));
        end
    endtask

    initial begin
        // Reset state
        tick;
        tick;
        chk("rst_Weight", 64'(Weight_o), 64'd0);
        chk("rst_In", 64'(In_o), 64'd0);
        chk("rst_enW", 64'(enW_o), 64'd0);
        chk("rst_enI", 64'(enI_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_w_ready", 64'(w_ready_o), 64'd1);
        chk("rst_x_ready", 64'(x_ready_o), 64'd0);
        RSTN = 1'b1;
        tick;

        // Tile 1: weights, ignored weight offers, lone x_last, bubble rows
        load_weights;
        w_valid_i = 1'b1;
        w_data_i  = 40'hFFFFFFFFFF;
        for (int c = 0; c < 2; c++) begin
            tick;
            chk("stream_enW", 64'(enW_o), 64'd0);
            chk("stream_Weight", 64'(Weight_o), 64'h0505050505);
            chk("stream_w_ready", 64'(w_ready_o), 64'd0);
        end
        w_valid_i = 1'b0;
        w_data_i  = '0;

        x_last_i = 1'b1;
        tick;
        x_last_i = 1'b0;
        chk("lone_last_x_ready", 64'(x_ready_o), 64'd1);
        chk("lone_last_enI", 64'(enI_o), 64'd0);
        chk("lone_last_done", 64'(done_o), 64'd0);

        rows[0] = 40'hA1A2A3A4A5; rv[0] = 1'b1;
        rows[1] = 40'hB1B2B3B4B5; rv[1] = 1'b1;
        rows[2] = 40'hEEEEEEEEEE; rv[2] = 1'b0;
        rows[3] = 40'hC1C2C3C4C5; rv[3] = 1'b1;
        stream_tile(4);

        // Tile 2: single row with last
        load_weights;
        rows[0] = 40'h1122334455; rv[0] = 1'b1;
        stream_tile(1);

        // Tile 3: reset two cycles into DRAIN
        load_weights;
        x_valid_i = 1'b1;
        x_data_i  = 40'h0102030405;
        x_last_i  = 1'b1;
        tick;
        x_valid_i = 1'b0;
        x_data_i  = '0;
        x_last_i  = 1'b0;
        chk("drain_x_ready", 64'(x_ready_o), 64'd0);
        tick;
        RSTN = 1'b0;
        tick;
        RSTN = 1'b1;
        chk("mid_rst_In", 64'(In_o), 64'd0);
        chk("mid_rst_enI", 64'(enI_o), 64'd0);
        chk("mid_rst_Weight", 64'(Weight_o), 64'd0);
        chk("mid_rst_enW", 64'(enW_o), 64'd0);
        chk("mid_rst_done", 64'(done_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_w_ready", 64'(w_ready_o), 64'd1);
        w_valid_i = 1'b1;
        w_data_i  = 40'h0A0B0C0D0E;
        tick;
        w_valid_i = 1'b0;
        chk("post_rst_Weight", 64'(Weight_o), 64'h0A0B0C0D0E);
        chk("post_rst_enW", 64'(enW_o), 64'd1);
        chk("post_rst_busy", 64'(busy_o), 64'd1);
        for (int c = 0; c < 6; c++) begin
            tick;
            chk("post_rst_no_done", 64'(done_o), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
